// File: rtl/div_result_buffer.sv
// div_result_buffer
// Two-entry FIFO that captures quotient/remainder results from the unsigned
// divider core. It presents them downstream over a valid/ready handshake.
//
// Ports:
//   i_clk      system clock, all state on posedge
//   rst_n      synchronous active-low reset
//   done       one-cycle result strobe from the divider
//   q_in/r_in  quotient / remainder from the divider
//   dz_in      divide-by-zero flag for this result
//   full       buffer holds DEPTH entries; the divider must not start
//   res_valid  head entry available
//   res_ready  downstream accepts head entry
//   q_out/r_out/dz_out  head entry (registered)
//   count      entries held, 0..2
//   overflow   sticky: a done strobe was dropped
//   clr_ovf    clears overflow (a drop in the same cycle wins)
module div_result_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic             done,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] r_in,
  input  logic             dz_in,
  output logic             full,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             dz_out,
  output logic [1:0]       count,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam logic [1:0] LP_DEPTH = 2'(DEPTH);

  logic [WIDTH-1:0] r_mem_q  [2];
  logic [WIDTH-1:0] r_mem_r  [2];
  logic             r_mem_dz [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             r_full;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_dz_out;
  logic             r_overflow;

  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [1:0]       w_count_nxt;
  logic             w_rptr_nxt;
  logic [WIDTH-1:0] w_head_q;
  logic [WIDTH-1:0] w_head_r;
  logic             w_head_dz;

  // A pop in the same cycle frees a slot, so a full buffer still accepts.
  // rst_n gates push so the reset-less storage ignores done during reset.
  assign w_pop  = r_res_valid && res_ready;
  assign w_push = rst_n && done && ((r_count != LP_DEPTH) || w_pop);
  assign w_drop = done && (r_count == LP_DEPTH) && !w_pop;

  always_comb begin
    w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
    w_rptr_nxt  = r_rptr ^ w_pop;
    w_head_q    = r_mem_q[w_rptr_nxt];
    w_head_r    = r_mem_r[w_rptr_nxt];
    w_head_dz   = r_mem_dz[w_rptr_nxt];
    // The next head is the entry being written this cycle, so bypass the
    // storage. This happens on an empty push or a push+pop with one entry.
    if (w_push && (r_wptr == w_rptr_nxt)) begin
      w_head_q  = q_in;
      w_head_r  = r_in;
      w_head_dz = dz_in;
    end
  end

  // Storage stage: entries are write-only from the divider side, no reset
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_q[r_wptr]  <= q_in;
      r_mem_r[r_wptr]  <= r_in;
      r_mem_dz[r_wptr] <= dz_in;
    end
  end

  // Control and output stage: pointers, count, flags and head copy
  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= 2'd0;
      r_full      <= 1'b0;
      r_res_valid <= 1'b0;
      r_q_out     <= '0;
      r_r_out     <= '0;
      r_dz_out    <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_wptr      <= r_wptr ^ w_push;
      r_rptr      <= w_rptr_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == LP_DEPTH);
      r_res_valid <= (w_count_nxt != 2'd0);
      // Outputs keep their last values once the buffer drains.
      if (w_count_nxt != 2'd0) begin
        r_q_out  <= w_head_q;
        r_r_out  <= w_head_r;
        r_dz_out <= w_head_dz;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign full      = r_full;
  assign res_valid = r_res_valid;
  assign q_out     = r_q_out;
  assign r_out     = r_r_out;
  assign dz_out    = r_dz_out;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_div_result_buffer.sv
module tb_div_result_buffer;

  localparam int WIDTH = 4;

  logic             i_clk = 1'b0;
  logic             rst_n;
  logic             done;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] r_in;
  logic             dz_in;
  logic             full;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic             dz_out;
  logic [1:0]       count;
  logic             overflow;
  logic             clr_ovf;

  int checks   = 0;
  int failures = 0;

  // expected entries packed as {dz, r, q}
  logic [2*WIDTH:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  div_result_buffer #(.WIDTH(WIDTH), .DEPTH(2)) dut (
    .i_clk    (i_clk),
    .rst_n    (rst_n),
    .done     (done),
    .q_in     (q_in),
    .r_in     (r_in),
    .dz_in    (dz_in),
    .full     (full),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .q_out    (q_out),
    .r_out    (r_out),
    .dz_out   (dz_out),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and status is sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_done(input logic [3:0] q, input logic [3:0] r,
                            input logic dz, input bit expect_accept);
    done  = 1'b1;
    q_in  = q;
    r_in  = r;
    dz_in = dz;
    if (expect_accept) exp_q.push_back({dz, r, q});
  endtask

  task automatic idle_done();
    done  = 1'b0;
    q_in  = '0;
    r_in  = '0;
    dz_in = 1'b0;
  endtask

  // Scoreboard monitor: on every accepted handshake compare the head to the queue front.
  task automatic monitor();
    logic [2*WIDTH:0] e;
    forever begin
      @(negedge i_clk);
      if (rst_n && res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected: got q=%0d r=%0d dz=%0d with nothing expected",
                   q_out, r_out, dz_out);
        end else begin
          e = exp_q.pop_front();
          if ({dz_out, r_out, q_out} !== e) begin
            failures++;
            $display("FAIL pop_data: got q=%0d r=%0d dz=%0d expected q=%0d r=%0d dz=%0d",
                     q_out, r_out, dz_out, e[3:0], e[7:4], e[8]);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst_n = 1'b0; res_ready = 1'b0; clr_ovf = 1'b0;
    idle_done();
    cyc(); cyc();
    rst_n = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_q", q_out, 0);
    chk("rst_r", r_out, 0);
    chk("rst_dz", dz_out, 0);

    // single result 13/3 = 4 r1
    res_ready = 1'b1;
    drive_done(4, 1, 0, 1);
    cyc(); idle_done();
    chk("single_valid", res_valid, 1);
    chk("single_q", q_out, 4);
    chk("single_r", r_out, 1);
    cyc();
    chk("single_valid_after", res_valid, 0);
    chk("single_count_after", count, 0);

    // backpressure fill
    res_ready = 1'b0;
    drive_done(4, 1, 0, 1); cyc();
    drive_done(2, 0, 0, 1); cyc();
    idle_done();
    chk("fill_count", count, 2);
    chk("fill_full", full, 1);
    chk("fill_q", q_out, 4);
    chk("fill_r", r_out, 1);
    cyc(); cyc();
    chk("hold_valid", res_valid, 1);
    chk("hold_q", q_out, 4);
    chk("hold_r", r_out, 1);

    // overflow: third result dropped
    drive_done(15, 0, 0, 0); cyc(); idle_done();
    chk("drop_ovf", overflow, 1);
    chk("drop_count", count, 2);
    chk("drop_q", q_out, 4);
    cyc();
    chk("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);
    clr_ovf = 1'b1; drive_done(15, 0, 0, 0); cyc();
    clr_ovf = 1'b0; idle_done();
    chk("ovf_set_wins", overflow, 1);
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    chk("ovf_clr2", overflow, 0);

    // drain: (4,1) then (2,0)
    res_ready = 1'b1;
    cyc(); cyc();
    chk("drain_count", count, 0);
    chk("drain_valid", res_valid, 0);

    // full plus simultaneous pop
    res_ready = 1'b0;
    drive_done(1, 1, 0, 1); cyc();
    drive_done(3, 0, 0, 1); cyc();
    idle_done();
    chk("fp_count_pre", count, 2);
    res_ready = 1'b1;
    drive_done(7, 2, 0, 1); cyc();
    idle_done(); res_ready = 1'b0;
    chk("fp_count", count, 2);
    chk("fp_ovf", overflow, 0);
    chk("fp_head_q", q_out, 3);
    res_ready = 1'b1;
    cyc(); cyc();
    chk("fp_drain_count", count, 0);

    // divide-by-zero passthrough
    res_ready = 1'b0;
    drive_done(4'hF, 4'h9, 1, 1); cyc(); idle_done();
    chk("dz_flag", dz_out, 1);
    chk("dz_q", q_out, 15);
    chk("dz_r", r_out, 9);
    res_ready = 1'b1;
    cyc();
    chk("dz_count", count, 0);

    // reset mid-operation (entries discarded, not expected downstream)
    res_ready = 1'b0;
    drive_done(5, 5, 0, 0); cyc();
    drive_done(6, 6, 0, 0); cyc();
    drive_done(9, 9, 0, 0); cyc();
    idle_done();
    chk("pre_rst_count", count, 2);
    chk("pre_rst_ovf", overflow, 1);
    rst_n = 1'b0; res_ready = 1'b1;
    drive_done(9, 9, 0, 0); cyc();
    rst_n = 1'b1; res_ready = 1'b0; idle_done();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_ovf", overflow, 0);
    res_ready = 1'b1;
    drive_done(8, 3, 0, 1); cyc(); idle_done();
    chk("post_rst_count", count, 1);
    chk("post_rst_q", q_out, 8);
    chk("post_rst_r", r_out, 3);
    cyc();
    chk("post_rst_empty", count, 0);
    cyc();
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_result_buffer.md
Name: div_result_buffer

Overview:
- Consumer-side counterpart to the divider's operand load registers.
- Captures each quotient/remainder pair the unsigned divider core emits on its single-cycle done pulse.
- Holds up to two results in a FIFO and presents them downstream over a valid/ready handshake.
- Tells the divider controller when it cannot accept a new result, so results are held back rather than lost.

Parameters:
- WIDTH, 4, bit width of quotient and remainder (matches divisor register width).
- DEPTH, 2, number of buffered results; fixed at 2, other values unsupported.

Ports:
- i_clk  input  1  system clock; all state on posedge.
- rst_n  input  1  synchronous active-low reset.
- done  input  1  one-cycle pulse from divider: q_in/r_in/dz_in valid this cycle.
- q_in  input  WIDTH  quotient from divider.
- r_in  input  WIDTH  remainder from divider.
- dz_in  input  1  divide-by-zero flag for this result.
- full  output  1  buffer holds DEPTH entries; divider controller must not start a new division.
- res_valid  output  1  head entry available.
- res_ready  input  1  downstream accepts head entry.
- q_out  output  WIDTH  head quotient.
- r_out  output  WIDTH  head remainder.
- dz_out  output  1  head divide-by-zero flag.
- count  output  2  entries held, 0..2.
- overflow  output  1  sticky: a done pulse was dropped.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Reset (rst_n=0 at posedge): count=0, full=0, res_valid=0, q_out=0, r_out=0, dz_out=0, overflow=0, pointers=0. Reset mid-operation discards all stored entries; res_ready is ignored that cycle.
- Storage: two entries of {dz, r, q}, plus write pointer, read pointer and count registers. Order is strict FIFO.
- pop = res_valid && res_ready.
- push = done && (count<2 || pop).
  - When full, a same-cycle pop frees a slot, so the result is accepted.
- Push: entry written at the write pointer; write pointer toggles.
- Pop: read pointer toggles.
- count next = count + push - pop.
  - Push and pop together leave count unchanged.
  - Push and pop together at count=1 with a single entry: head advances to the new entry; res_valid stays 1.
- Latency:
  - A result pushed into an empty buffer appears on res_valid/q_out/r_out/dz_out in the cycle after done. There is no combinational path from done or q_in to the outputs.
  - res_ready-to-next-head is also 1 cycle: the outputs are registered copies of the entry at the read pointer, updated on the same edge as the pointers.
- res_valid = (count != 0), registered.
- full = (count == 2), registered.
- When res_valid=0, q_out/r_out/dz_out hold their last values (don't-care to consumers; the bench must not check them).
- Hold rule: while res_valid=1 and res_ready=0, q_out/r_out/dz_out and res_valid are stable.
- Drop: done when count=2 and no pop → data discarded, count unchanged, overflow set to 1 on the next edge.
- overflow stays 1 until clr_ovf=1. If a drop and clr_ovf occur in the same cycle, set wins and overflow=1.
- dz_in is passed through unchanged. q_in/r_in are stored verbatim even when dz_in=1; no arithmetic is performed in this block.
- done while rst_n=0 is ignored.

Test Plan:
- Single result, WIDTH=4: done with q_in=4, r_in=1, dz_in=0 (13/3), res_ready=1 → next cycle res_valid=1, q_out=4, r_out=1; following cycle res_valid=0, count=0.
- Backpressure fill, res_ready=0:
  - Push (4,1), then (2,0) for 8/4 → count=2, full=1.
  - Head stays q_out=4, r_out=1 until res_ready=1.
  - Pops then return (4,1) followed by (2,0).
- Overflow:
  - With full=1 and res_ready=0, a third done (q_in=15, r_in=0) → overflow=1, count=2, and the entries are unchanged.
  - clr_ovf=1 → overflow=0.
  - clr_ovf together with another drop → overflow stays 1.
- Full plus simultaneous pop:
  - count=2, res_ready=1 and done with q_in=7, r_in=2 in the same cycle → count stays 2, overflow=0.
  - Drain order: second entry, then (7,2).
- Divide-by-zero passthrough: done with dz_in=1, q_in=4'hF, r_in=4'h9 → dz_out=1, q_out=4'hF, r_out=4'h9.
- Reset mid-operation: count=2, then rst_n=0 for one cycle → count=0, res_valid=0, full=0, overflow=0; the next done is received as the only entry.
